// File: rtl/ccff_shift_chain.sv
`default_nettype none
// ============================================================================
//  Module      : ccff_shift_chain
//  Description : Serial configuration flip-flop chain for the embedded FPGA
//                fabric. Shifts the bitstream one bit per enabled programming
//                clock, exposes every stage as a parallel word, counts shifted
//                bits (saturating) and flags a completed load.
//                Optional macro CCFF_CRC_EN adds a running CRC-16-CCITT over
//                the shifted-in bits; without it crc reads 16'h0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccff_shift_chain #(
   parameter int CHAIN_LEN = 29696,
   // Derived from CHAIN_LEN; not meant to be overridden.
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 prog_clk,
   input  logic                 prog_reset,
   input  logic                 shift_en,
   input  logic                 ccff_head,
   output logic                 ccff_tail,
   output logic [CHAIN_LEN-1:0] cfg_bits,
   output logic [CNT_W-1:0]     bit_count,
   output logic                 config_done,
   output logic [15:0]          crc
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CHAIN_LEN);

   logic [CHAIN_LEN-1:0] r_chain;
   logic [CNT_W-1:0]     r_count;
   logic                 r_done;
   logic [CNT_W-1:0]     w_cnt_next;

   // Next shift count: advance on each shift, freeze once the chain is full.
   always_comb begin
      w_cnt_next = r_count;
      if (shift_en && (r_count != c_CNT_MAX)) begin
         w_cnt_next = r_count + CNT_W'(1);
      end
   end

   // Chain, counter and done flag; reset wins over shift.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         r_chain <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         if (shift_en) begin
            r_chain <= {r_chain[CHAIN_LEN-2:0], ccff_head};
         end
         r_count <= w_cnt_next;
         // Registered so done rises on the same edge as the final shift.
         r_done  <= (w_cnt_next == c_CNT_MAX);
      end
   end

   assign cfg_bits    = r_chain;
   assign ccff_tail   = r_chain[CHAIN_LEN-1];
   assign bit_count   = r_count;
   assign config_done = r_done;

`ifdef CCFF_CRC_EN
   generate
      if (1) begin : g_crc
         logic [15:0] r_crc;
         logic        w_fb;

         assign w_fb = r_crc[15] ^ ccff_head;

         // CRC-16-CCITT, MSB-first, one bit per shift.
         always_ff @(posedge prog_clk) begin
            if (prog_reset) begin
               r_crc <= 16'hFFFF;
            end else if (shift_en) begin
               r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
            end
         end

         assign crc = r_crc;
      end
   endgenerate
`else
   generate
      if (1) begin : g_no_crc
         assign crc = 16'h0000;
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_shift_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccff_shift_chain
//  Description : Self-checking bench for ccff_shift_chain. A short chain
//                (CHAIN_LEN=8) is driven with directed and random traffic and
//                compared with a history-queue reference; a full-size chain
//                checks single-pulse traversal and done timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_shift_chain;

   localparam int c_SL   = 8;
   localparam int c_SW   = $clog2(c_SL + 1);
   localparam int c_BL   = 29696;
   localparam int c_BW   = $clog2(c_BL + 1);
`ifdef CCFF_CRC_EN
   localparam bit c_CRC_ON = 1'b1;
`else
   localparam bit c_CRC_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Small chain signals
   logic             s_rst, s_en, s_head;
   logic             s_tail, s_done;
   logic [c_SL-1:0]  s_cfg;
   logic [c_SW-1:0]  s_cnt;
   logic [15:0]      s_crc;

   // Full-size chain signals
   logic             b_rst, b_en, b_head;
   logic             b_tail, b_done;
   logic [c_BL-1:0]  b_cfg;
   logic [c_BW-1:0]  b_cnt;
   logic [15:0]      b_crc;

   ccff_shift_chain #(.CHAIN_LEN(c_SL)) u_small (
      .prog_clk(clk), .prog_reset(s_rst), .shift_en(s_en), .ccff_head(s_head),
      .ccff_tail(s_tail), .cfg_bits(s_cfg), .bit_count(s_cnt),
      .config_done(s_done), .crc(s_crc)
   );

   ccff_shift_chain #(.CHAIN_LEN(c_BL)) u_big (
      .prog_clk(clk), .prog_reset(b_rst), .shift_en(b_en), .ccff_head(b_head),
      .ccff_tail(b_tail), .cfg_bits(b_cfg), .bit_count(b_cnt),
      .config_done(b_done), .crc(b_crc)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model for the small chain: every bit shifted since reset.
   bit          hist[$];
   logic [15:0] m_crc = 16'hFFFF;

   function automatic logic [15:0] crc_next(input logic [15:0] c, input bit b);
      logic [16:0] t;
      t = {c, 1'b0};
      if (c[15] != b) t[15:0] = t[15:0] ^ 16'h1021;
      return t[15:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_small();
      int          n;
      logic [31:0] e_cfg;
      int          e_cnt;
      n = hist.size();
      e_cfg = '0;
      for (int i = 0; i < c_SL; i++) begin
         if (n > i) e_cfg[i] = hist[n-1-i];
      end
      e_cnt = (n < c_SL) ? n : c_SL;
      chk("cfg_bits",    32'(s_cfg),  e_cfg);
      chk("ccff_tail",   32'(s_tail), 32'(e_cfg[c_SL-1]));
      chk("bit_count",   32'(s_cnt),  32'(e_cnt));
      chk("config_done", 32'(s_done), 32'(e_cnt == c_SL));
      chk("crc",         32'(s_crc),  c_CRC_ON ? 32'(m_crc) : 32'h0);
   endtask

   // One small-chain clock: drive at negedge, model at posedge, check at negedge.
   task automatic step_s(input bit rst, input bit en, input bit hd);
      s_rst = rst; s_en = en; s_head = hd;
      @(posedge clk);
      if (rst) begin
         hist.delete();
         m_crc = 16'hFFFF;
      end else if (en) begin
         hist.push_back(hd);
         m_crc = crc_next(m_crc, hd);
      end
      @(negedge clk);
      check_small();
   endtask

   task automatic step_b(input bit rst, input bit en, input bit hd);
      b_rst = rst; b_en = en; b_head = hd;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] pat;
      s_rst = 1'b1; s_en = 1'b0; s_head = 1'b0;
      b_rst = 1'b1; b_en = 1'b0; b_head = 1'b0;
      @(negedge clk);

      // Reset held for two edges
      step_s(1, 0, 0);
      step_s(1, 1, 1);

      // CRC of a single 0 and a single 1 from reset
      step_s(0, 1, 0);
      chk("crc_one_zero", 32'(s_crc), c_CRC_ON ? 32'hEFDF : 32'h0);
      step_s(1, 0, 0);
      step_s(0, 1, 1);
      chk("crc_one_one", 32'(s_crc), c_CRC_ON ? 32'hFFFE : 32'h0);

      // Load a known word MSB first, then hold for ten cycles
      step_s(1, 0, 0);
      pat = 8'b1011_0010;
      for (int i = 7; i >= 0; i--) step_s(0, 1, pat[i]);
      for (int i = 0; i < 10; i++) step_s(0, 0, 1'($urandom));
      chk("hold_cfg", 32'(s_cfg), 32'hB2);
      chk("hold_cnt", 32'(s_cnt), 32'd8);

      // Reset in the middle of a load, then a fresh full load
      step_s(1, 0, 0);
      for (int i = 0; i < 5; i++) step_s(0, 1, 1);
      step_s(1, 1, 1);
      chk("midrst_cfg", 32'(s_cfg), 32'h0);
      for (int i = 0; i < 8; i++) step_s(0, 1, 1'($urandom));
      chk("midrst_done", 32'(s_done), 32'd1);

      // Saturation: 20 random shifts
      step_s(1, 0, 0);
      for (int i = 0; i < 20; i++) step_s(0, 1, 1'($urandom));
      chk("sat_cnt", 32'(s_cnt), 32'd8);

      // Random traffic with gaps and occasional resets
      for (int i = 0; i < 400; i++) begin
         step_s(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), 1'($urandom));
      end
      s_rst = 1'b1; s_en = 1'b0;

      // Full-size chain: single pulse on shift 2
      step_b(1, 0, 0);
      step_b(1, 1, 1);
      chk("big_rst_tail", 32'(b_tail), 32'd0);
      chk("big_rst_cnt",  32'(b_cnt),  32'd0);
      chk("big_rst_done", 32'(b_done), 32'd0);
      chk("big_rst_crc",  32'(b_crc),  c_CRC_ON ? 32'hFFFF : 32'h0);
      for (int s = 1; s <= c_BL + 6; s++) begin
         step_b(0, 1, (s == 2));
         chk("big_tail", 32'(b_tail), 32'(s == c_BL + 1));
         chk("big_done", 32'(b_done), 32'(s >= c_BL));
      end
      chk("big_cnt", 32'(b_cnt), 32'(c_BL));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
